// File: rtl/ldpc_bf_decoder.sv
// Hard-decision bit-flipping decoder for the (12,4) LDPC code: one word in flight, valid/ready on both sides.
// Optional LDPC_DEC_ERR_CNT_EN adds saturating corrected/failed word counters.
module ldpc_bf_decoder #(
  parameter int MAX_ITER = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_code,
  output logic [3:0]  out_msg,
  output logic [3:0]  out_iter,
  output logic        out_corrected,
`ifdef LDPC_DEC_ERR_CNT_EN
  output logic [15:0] err_corr_cnt,
  output logic [15:0] err_fail_cnt,
`endif
  output logic        out_fail
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; a producer holds valid and its data stable until that edge.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYND = 2'd1;
  localparam logic [1:0] EVAL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] MAX_ITER_L = 4'(MAX_ITER);

  logic [1:0]  state;
  logic [11:0] work;
  logic [11:0] orig;
  logic [7:0]  synd;
  logic [3:0]  iter;
  logic [7:0]  synd_next;
  logic [3:0]  best_idx;
  logic signed [4:0] best_score;
  logic signed [4:0] score;
  logic [11:0] flip_mask;

  // Column j of the parity-check matrix: bit i set when check S_i contains c_j.
  function automatic logic [7:0] col_mask(input int j);
    case (j)
      0:       return 8'hC6;
      1:       return 8'hD9;
      2:       return 8'hFB;
      3:       return 8'h80;
      4:       return 8'h19;
      5:       return 8'h40;
      6:       return 8'h20;
      7:       return 8'h10;
      8:       return 8'h08;
      9:       return 8'h04;
      10:      return 8'h02;
      11:      return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    synd_next = '0;
    for (int j = 0; j < 12; j++)
      if (work[j]) synd_next = synd_next ^ col_mask(j);
  end

  // Score = unsatisfied - satisfied checks; '>=' hands ties to the higher index.
  always_comb begin
    best_idx   = '0;
    best_score = -5'sd16;
    score      = '0;
    for (int j = 0; j < 12; j++) begin
      score = $signed({1'b0, popcnt8(synd & col_mask(j))})
            - $signed({1'b0, popcnt8(~synd & col_mask(j))});
      if (score >= best_score) begin
        best_score = score;
        best_idx   = 4'(j);
      end
    end
    flip_mask = 12'd1 << best_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      work          <= '0;
      orig          <= '0;
      synd          <= '0;
      iter          <= '0;
      out_code      <= '0;
      out_msg       <= '0;
      out_iter      <= '0;
      out_corrected <= 1'b0;
      out_fail      <= 1'b0;
`ifdef LDPC_DEC_ERR_CNT_EN
      err_corr_cnt  <= '0;
      err_fail_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_code;
            orig  <= in_code;
            iter  <= '0;
            state <= SYND;
          end
        end
        SYND: begin
          synd  <= synd_next;
          state <= EVAL;
        end
        EVAL: begin
          if (synd == 8'd0 || iter == MAX_ITER_L) begin
            out_code      <= work;
            out_msg       <= {work[4], work[2:0]};
            out_iter      <= iter;
            out_corrected <= (work != orig);
            out_fail      <= (synd != 8'd0);
            state         <= DONE;
          end else begin
            work  <= work ^ flip_mask;
            iter  <= iter + 4'd1;
            state <= SYND;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
`ifdef LDPC_DEC_ERR_CNT_EN
            if (out_corrected && err_corr_cnt != 16'hFFFF) err_corr_cnt <= err_corr_cnt + 16'd1;
            if (out_fail && err_fail_cnt != 16'hFFFF) err_fail_cnt <= err_fail_cnt + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// Directed bench for ldpc_bf_decoder: default MAX_ITER instance plus a MAX_ITER=1 instance.
module tb_ldpc_bf_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] in_code, out_code;
  logic [3:0]  out_msg, out_iter;
  logic        out_corrected, out_fail;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [11:0] in_code1, out_code1;
  logic [3:0]  out_msg1, out_iter1;
  logic        out_corrected1, out_fail1;

`ifdef LDPC_DEC_ERR_CNT_EN
  logic [15:0] err_corr_cnt, err_fail_cnt, err_corr_cnt1, err_fail_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ldpc_bf_decoder #(.MAX_ITER(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_msg(out_msg),
    .out_iter(out_iter), .out_corrected(out_corrected),
`ifdef LDPC_DEC_ERR_CNT_EN
    .err_corr_cnt(err_corr_cnt), .err_fail_cnt(err_fail_cnt),
`endif
    .out_fail(out_fail)
  );

  ldpc_bf_decoder #(.MAX_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_code(in_code1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_code(out_code1), .out_msg(out_msg1),
    .out_iter(out_iter1), .out_corrected(out_corrected1),
`ifdef LDPC_DEC_ERR_CNT_EN
    .err_corr_cnt(err_corr_cnt1), .err_fail_cnt(err_fail_cnt1),
`endif
    .out_fail(out_fail1)
  );

  // Present one word; returns 1ns after the accepting edge.
  task automatic send_word(input logic [11:0] code);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted from the accepting edge (which counts as 1) until out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_word(input string name, input logic [11:0] code,
                          input logic [21:0] exp_res, input int exp_lat);
    int lat;
    send_word(code);
    wait_valid(lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if ({out_code, out_msg, out_iter, out_corrected, out_fail} !== exp_res) begin
      errors++;
      $display("FAIL %s result: got code=%h msg=%h iter=%0d corr=%b fail=%b expected %h",
               name, out_code, out_msg, out_iter, out_corrected, out_fail, exp_res);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset handshake: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    checks++;
    if ({out_code, out_msg, out_iter, out_corrected, out_fail} !== 22'd0) begin
      errors++;
      $display("FAIL reset outputs: got code=%h msg=%h iter=%0d corr=%b fail=%b expected all 0",
               out_code, out_msg, out_iter, out_corrected, out_fail);
    end
`ifdef LDPC_DEC_ERR_CNT_EN
    checks++;
    if ({err_corr_cnt, err_fail_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset counters: got %0d %0d expected 0 0", err_corr_cnt, err_fail_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean;
    run_word("clean", 12'h03A, {12'h03A, 4'hA, 4'd0, 1'b0, 1'b0}, 3);
  endtask

  task automatic test_msg_bit_error;
    run_word("msg_c1", 12'h038, {12'h03A, 4'hA, 4'd1, 1'b1, 1'b0}, 5);
  endtask

  task automatic test_parity_bit_error;
    run_word("parity_c10", 12'hFFF, {12'hBFF, 4'hF, 4'd1, 1'b1, 1'b0}, 5);
  endtask

  task automatic test_double_error;
    run_word("double_c2c1", 12'h006, {12'h446, 4'h6, 4'd2, 1'b1, 1'b0}, 7);
  endtask

  task automatic test_max_iter;
    int lat;
    @(negedge clk);
    in_code1  = 12'h006;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL max_iter latency: got %0d expected 5", lat);
    end
    checks++;
    if ({out_code1, out_msg1, out_iter1, out_corrected1, out_fail1} !==
        {12'h406, 4'h6, 4'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL max_iter result: got code=%h msg=%h iter=%0d corr=%b fail=%b expected 406 6 1 1 1",
               out_code1, out_msg1, out_iter1, out_corrected1, out_fail1);
    end
    @(posedge clk);
    #1;
`ifdef LDPC_DEC_ERR_CNT_EN
    checks++;
    if ({err_corr_cnt1, err_fail_cnt1} !== {16'd1, 16'd1}) begin
      errors++;
      $display("FAIL max_iter counters: got %0d %0d expected 1 1", err_corr_cnt1, err_fail_cnt1);
    end
`endif
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_word("bp_first", 12'h03A, {12'h03A, 4'hA, 4'd0, 1'b0, 1'b0}, 3);
    in_code  = 12'h038;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, out_code, out_iter, out_corrected, out_fail} !==
          {1'b1, 1'b0, 12'h03A, 4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_frozen cycle %0d: got valid=%b ready=%b code=%h iter=%0d expected 1 0 03a 0",
                 i, out_valid, in_ready, out_code, out_iter);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: got in_ready=%b expected 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if ({lat[3:0], out_code, out_iter, out_corrected} !== {4'd5, 12'h03A, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL bp_second_result: got lat=%0d code=%h iter=%0d corr=%b expected 5 03a 1 1",
               lat, out_code, out_iter, out_corrected);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int seen;
`ifdef LDPC_DEC_ERR_CNT_EN
    checks++;
    if ({err_corr_cnt, err_fail_cnt} !== {16'd4, 16'd0}) begin
      errors++;
      $display("FAIL counters_before_reset: got %0d %0d expected 4 0", err_corr_cnt, err_fail_cnt);
    end
`endif
    send_word(12'h038);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, out_code, out_iter} !== {1'b0, 1'b1, 12'h000, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b ready=%b code=%h iter=%0d expected 0 1 000 0",
               out_valid, in_ready, out_code, out_iter);
    end
`ifdef LDPC_DEC_ERR_CNT_EN
    checks++;
    if ({err_corr_cnt, err_fail_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid counters: got %0d %0d expected 0 0", err_corr_cnt, err_fail_cnt);
    end
`endif
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_output: got %0d valid cycles expected 0", seen);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_code    = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_code1   = '0;
    out_ready1 = 1'b1;
    test_reset;
    test_clean;
    test_msg_bit_error;
    test_parity_bit_error;
    test_double_error;
    test_max_iter;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_bf_decoder.md
Name: ldpc_bf_decoder

Overview:
- Hard-decision bit-flipping decoder for the team's systematic (12,4) LDPC code.
- Sits directly downstream of the encoder/channel. It consumes 12-bit received words and iteratively corrects them to a valid codeword.
- Outputs the corrected codeword, the recovered 4-bit message and a decode status.
- Valid/ready handshake on both sides; one word in flight at a time.

Parameters:
- MAX_ITER, 8, maximum flip iterations before declaring failure (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept a word
- in_code  in  12  received hard-decision word, same bit layout as the encoder output
- out_valid  out  1  decode result valid
- out_ready  in  1  downstream accepts result
- out_code  out  12  corrected codeword
- out_msg  out  4  recovered message {out_code[4], out_code[2:0]}
- out_iter  out  4  number of flips performed
- out_corrected  out  1  out_code differs from in_code
- out_fail  out  1  syndrome still nonzero after MAX_ITER flips

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - FSM goes to IDLE.
  - in_ready=1; out_valid=0; out_code=0, out_msg=0, out_iter=0, out_corrected=0, out_fail=0.
  - Reset mid-decode aborts the word; nothing is emitted.
- Checks (XOR over bits c[11:0]), 8 rows:
  - S0=c11^c4^c2^c1
  - S1=c10^c2^c0
  - S2=c9^c0
  - S3=c8^c4^c2^c1
  - S4=c7^c4^c2^c1
  - S5=c6^c2
  - S6=c5^c2^c1^c0
  - S7=c3^c2^c1^c0
- Bit degrees: c0=4, c1=5, c2=7, c4=3; every other bit has degree 1.
- Score of bit j = (unsatisfied checks containing j) - (satisfied checks containing j). Signed 4-bit, range -7..+7.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_code into the work register and the original copy, clear the iteration counter, go to SYND.
  - SYND: register the 8-bit syndrome of the work register (1 cycle), go to EVAL.
  - EVAL:
    - Syndrome==0: go to DONE, fail=0.
    - Else if iter==MAX_ITER: go to DONE, fail=1.
    - Else flip exactly one bit: the bit with maximum score. Ties go to the highest index. Increment iter, go to SYND.
  - DONE: out_valid=1 and all outputs stable. On out_ready, go to IDLE, drop out_valid, raise in_ready.
- in_ready=0 in SYND, EVAL and DONE.
- Outputs are registered and update only on the EVAL->DONE transition.
- Latency from the accepting edge to out_valid high: 3 cycles for a clean word, plus 2 cycles per flip.
- out_corrected = (out_code != original in_code). It is valid when fail=1 too.
- out_valid held with out_ready=0: outputs stay frozen indefinitely.
- in_valid while busy: ignored, no loss, upstream must hold the word.
- Every check contains a degree-1 parity bit, so a nonzero syndrome always yields a positive max score. With the default MAX_ITER the decoder always terminates at a codeword (possibly a miscorrection).

Optional Feature:
- Macro LDPC_DEC_ERR_CNT_EN.
- When defined, add two outputs, err_corr_cnt[15:0] and err_fail_cnt[15:0]:
  - Saturating counters, cleared by rst.
  - Incremented on each DONE->IDLE handshake where out_corrected=1 (respectively out_fail=1).
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Clean word: in_code=12'h03A (msg 4'hA) -> out_code=12'h03A, out_msg=4'hA, iter=0, corrected=0, fail=0; out_valid 3 cycles after accept.
- Single error on message bit c1: in_code=12'h038 -> out_code=12'h03A, out_msg=4'hA, iter=1, corrected=1, fail=0; latency 5.
- Single error on parity bit c10 of an all-ones word: in_code=12'hFFF -> out_code=12'hBFF, out_msg=4'hF, iter=1.
- Double error c2,c1 on the all-zero codeword: in_code=12'h006 -> out_code=12'h446, out_msg=4'h6, iter=2, fail=0 (miscorrection). Same input with MAX_ITER=1 -> iter=1, fail=1, out_code=12'h406.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs frozen, in_ready=0, second in_valid ignored. Release -> the second word is accepted next cycle.
- Reset asserted during SYND of a word -> out_valid=0, in_ready=1 immediately. No result emitted; with LDPC_DEC_ERR_CNT_EN the counters read 0.
